// File: rtl/bram_fifo_pkg.sv
// Shared types and helpers for the BRAM-backed FWFT FIFO controller.
// Holds the output-buffer occupancy encoding and the count-width helper.
package bram_fifo_pkg;

    typedef enum logic [1:0] {
        OUT_EMPTY = 2'd0,
        OUT_ONE   = 2'd1,
        OUT_TWO   = 2'd2
    } out_occ_t;

    // count spans BRAM depth plus in-flight read plus two buffer slots
    function automatic int count_width(input int addr_width);
        return addr_width + 2;
    endfunction

endpackage

// File: rtl/fifo_out_skid.sv
// Two-entry output buffer that hides the BRAM read latency.
// Ports: clk, rst_n, push/push_data in; valid/ready/data out; occ out.
module fifo_out_skid
    import bram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  valid,
    input  logic                  ready,
    output logic [DATA_WIDTH-1:0] data,
    output out_occ_t              occ
);

    out_occ_t              state;
    out_occ_t              state_nxt;
    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] tail;
    logic                  pop;
    logic                  load_head;
    logic                  head_from_tail;
    logic                  load_tail;

    assign valid = (state != OUT_EMPTY);
    assign pop   = valid && ready;
    assign data  = head;
    assign occ   = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= OUT_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // The controller never pushes into a full buffer without a pop.
    always_comb begin
        state_nxt      = state;
        load_head      = 1'b0;
        head_from_tail = 1'b0;
        load_tail      = 1'b0;
        case (state)
            OUT_EMPTY: begin
                if (push) begin
                    state_nxt = OUT_ONE;
                    load_head = 1'b1;
                end
            end
            OUT_ONE: begin
                if (push && pop) begin
                    load_head = 1'b1;
                end else if (push) begin
                    state_nxt = OUT_TWO;
                    load_tail = 1'b1;
                end else if (pop) begin
                    state_nxt = OUT_EMPTY;
                end
            end
            OUT_TWO: begin
                if (pop) begin
                    load_head      = 1'b1;
                    head_from_tail = 1'b1;
                    if (push) begin
                        load_tail = 1'b1;
                    end else begin
                        state_nxt = OUT_ONE;
                    end
                end
            end
            default: begin
                state_nxt = OUT_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (load_head) begin
                head <= head_from_tail ? tail : push_data;
            end
            if (load_tail) begin
                tail <= push_data;
            end
        end
    end

endmodule

// File: rtl/bram_fifo_ctrl.sv
// FWFT FIFO controller driving a dual-port BRAM (A write, B read).
// Ports: wr_* / rd_* handshakes, count, mem_* BRAM pins.
// Optional BRAM_FIFO_STATS_EN adds max_level and ovf_attempts outputs.
module bram_fifo_ctrl
    import bram_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH+1:0] count,
`ifdef BRAM_FIFO_STATS_EN
    output logic [ADDR_WIDTH+1:0] max_level,
    output logic [15:0]           ovf_attempts,
`endif
    output logic [ADDR_WIDTH-1:0] mem_addr_a,
    output logic [DATA_WIDTH-1:0] mem_din_a,
    output logic                  mem_we_a,
    output logic [ADDR_WIDTH-1:0] mem_addr_b,
    input  logic [DATA_WIDTH-1:0] mem_dout_b,
    output logic                  mem_we_b
);

    localparam int CW = count_width(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_V = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   mem_count;
    logic                  inflight;
    logic                  wr_acc;
    logic                  pop;
    logic                  rd_en;
    logic [2:0]            level;
    out_occ_t              occ;
    logic [1:0]            occ_bits;

    assign wr_ready = (mem_count != DEPTH_V);
    // Gating with rst_n keeps the BRAM write strobe quiet during reset.
    assign wr_acc   = wr_valid && wr_ready && rst_n;
    assign pop      = rd_valid && rd_ready;
    assign occ_bits = occ;

    // Keep at most two words between the in-flight read and the buffer.
    assign level = {1'b0, occ_bits} + {2'b00, inflight};
    assign rd_en = (mem_count != '0) && (level < 3'd2 + {2'b00, pop});

    assign mem_addr_a = wr_ptr;
    assign mem_din_a  = wr_data;
    assign mem_we_a   = wr_acc;
    assign mem_addr_b = rd_ptr;
    assign mem_we_b   = 1'b0;

    assign count = CW'(mem_count) + CW'(inflight) + CW'(occ_bits);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_count <= '0;
            inflight  <= 1'b0;
        end else begin
            inflight <= rd_en;
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_acc, rd_en})
                2'b10:   mem_count <= mem_count + 1'b1;
                2'b01:   mem_count <= mem_count - 1'b1;
                default: mem_count <= mem_count;
            endcase
        end
    end

    fifo_out_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight),
        .push_data (mem_dout_b),
        .valid     (rd_valid),
        .ready     (rd_ready),
        .data      (rd_data),
        .occ       (occ)
    );

`ifdef BRAM_FIFO_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_level    <= '0;
            ovf_attempts <= '0;
        end else begin
            if (count > max_level) begin
                max_level <= count;
            end
            if (wr_valid && !wr_ready && ovf_attempts != 16'hFFFF) begin
                ovf_attempts <= ovf_attempts + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Self-checking bench for bram_fifo_ctrl with ADDR_WIDTH = 4.
// Table-driven single-word vectors plus streaming/full/wrap/reset sequences.
module tb_bram_fifo_ctrl;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int CW = AW + 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [DW-1:0] wr_data = '0;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic [DW-1:0] rd_data;
    logic [CW-1:0] count;
    logic [AW-1:0] mem_addr_a;
    logic [DW-1:0] mem_din_a;
    logic          mem_we_a;
    logic [AW-1:0] mem_addr_b;
    logic [DW-1:0] mem_dout_b = '0;
    logic          mem_we_b;
`ifdef BRAM_FIFO_STATS_EN
    logic [CW-1:0] max_level;
    logic [15:0]   ovf_attempts;
`endif

    bram_fifo_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_data      (wr_data),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_data      (rd_data),
        .count        (count),
`ifdef BRAM_FIFO_STATS_EN
        .max_level    (max_level),
        .ovf_attempts (ovf_attempts),
`endif
        .mem_addr_a   (mem_addr_a),
        .mem_din_a    (mem_din_a),
        .mem_we_a     (mem_we_a),
        .mem_addr_b   (mem_addr_b),
        .mem_dout_b   (mem_dout_b),
        .mem_we_b     (mem_we_b)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] bram [0:(1<<AW)-1];

    always @(posedge clk) begin
        if (mem_we_a) bram[mem_addr_a] <= mem_din_a;
        mem_dout_b <= bram[mem_addr_b];
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wr_valid = 1'b1;
        wr_data = 8'hFF;
        rd_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wr_valid = 1'b0;
    endtask

    typedef struct {
        logic          wv;
        logic [DW-1:0] wd;
        logic          rr;
        logic          ev;
        logic [DW-1:0] ed;
        logic          cd;
        logic [CW-1:0] ec;
    } vec_t;

    vec_t vecs[9];

    int sent, rcvd, n, first_pop, last_pop, max_c;
    logic stalled_prev;
    logic [DW-1:0] held;
    logic [DW-1:0] val;
    logic [DW-1:0] q[$];

    initial begin
        vecs[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0, 6'd1};
        vecs[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 6'd1};
        vecs[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b1, 6'd1};
        vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 6'd0};
        vecs[4] = '{1'b1, 8'h11, 1'b1, 1'b0, 8'h00, 1'b0, 6'd1};
        vecs[5] = '{1'b1, 8'h22, 1'b0, 1'b0, 8'h00, 1'b0, 6'd2};
        vecs[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 1'b1, 6'd2};
        vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h22, 1'b1, 6'd1};
        vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 6'd0};

        // reset state, with wr_valid held high during reset
        rst_n = 1'b0;
        wr_valid = 1'b1;
        wr_data = 8'h77;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_count", count, 0);
        chk("rst_mem_we_a", mem_we_a, 0);
        chk("rst_mem_we_b", mem_we_b, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wr_valid = 1'b0;

        // single-word and short sequences, one vector per cycle
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            wr_valid = vecs[i].wv;
            wr_data = vecs[i].wd;
            rd_ready = vecs[i].rr;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_rd_valid", i), rd_valid, vecs[i].ev);
            chk($sformatf("vec%0d_count", i), count, vecs[i].ec);
            chk($sformatf("vec%0d_wr_ready", i), wr_ready, 1);
            if (vecs[i].cd)
                chk($sformatf("vec%0d_rd_data", i), rd_data, vecs[i].ed);
        end

        // streaming 256 words with both sides always ready
        do_reset();
        sent = 0; rcvd = 0; first_pop = -1; last_pop = -1; max_c = 0;
        for (int i = 0; i < 400 && rcvd < 256; i++) begin
            @(negedge clk);
            wr_valid = (sent < 256);
            wr_data = sent[7:0];
            rd_ready = 1'b1;
            if (int'(count) > max_c) max_c = int'(count);
            if (rd_valid) begin
                chk("stream_data", rd_data, rcvd[7:0]);
                if (rcvd == 0) first_pop = i;
                last_pop = i;
                rcvd++;
            end
            if (wr_valid && wr_ready) sent++;
            @(posedge clk);
        end
        chk("stream_rcvd", rcvd, 256);
        chk("stream_first_pop", first_pop, 3);
        chk("stream_last_pop", last_pop, 258);
        chk("stream_max_count", max_c, 3);

        // fill to full with reads blocked
        do_reset();
        sent = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            wr_valid = (sent < 20);
            wr_data = sent[7:0];
            rd_ready = 1'b0;
            if (wr_valid && wr_ready) sent++;
            @(posedge clk);
        end
        @(negedge clk);
        wr_valid = 1'b0;
        chk("full_accepted", sent, 18);
        chk("full_wr_ready", wr_ready, 0);
        chk("full_count", count, 18);
        rcvd = 0;
        for (int i = 0; i < 40 && rcvd < 18; i++) begin
            @(negedge clk);
            rd_ready = 1'b1;
            if (rd_valid) begin
                chk("full_drain_data", rd_data, rcvd[7:0]);
                rcvd++;
            end
            @(posedge clk);
        end
        @(negedge clk);
        rd_ready = 1'b0;
        chk("full_drain_rcvd", rcvd, 18);
        chk("full_drain_count", count, 0);
        chk("full_drain_wr_ready", wr_ready, 1);

        // wrap: 5 rounds of 10 writes then 10 reads
        do_reset();
        val = 8'h40;
        for (int r = 0; r < 5; r++) begin
            n = 0;
            for (int i = 0; i < 40 && n < 10; i++) begin
                @(negedge clk);
                wr_valid = 1'b1;
                wr_data = val;
                rd_ready = 1'b0;
                if (wr_ready) begin
                    q.push_back(val);
                    val = val + 8'd3;
                    n++;
                end
                @(posedge clk);
            end
            n = 0;
            for (int i = 0; i < 40 && n < 10; i++) begin
                @(negedge clk);
                wr_valid = 1'b0;
                rd_ready = 1'b1;
                if (rd_valid) begin
                    chk("wrap_data", rd_data, q.pop_front());
                    n++;
                end
                @(posedge clk);
            end
            chk("wrap_round_reads", n, 10);
        end
        @(negedge clk);
        rd_ready = 1'b0;
        chk("wrap_end_count", count, 0);

        // backpressure: reads ready ~30 % of cycles, writes continuous
        do_reset();
        sent = 0; rcvd = 0; stalled_prev = 1'b0; held = '0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            wr_valid = 1'b1;
            wr_data = sent[7:0];
            rd_ready = ($urandom_range(0, 99) < 30);
            if (stalled_prev) begin
                chk("bp_hold_valid", rd_valid, 1);
                chk("bp_hold_data", rd_data, held);
            end
            if (rd_valid && rd_ready) begin
                chk("bp_data", rd_data, rcvd[7:0]);
                rcvd++;
            end
            stalled_prev = rd_valid && !rd_ready;
            held = rd_data;
            if (wr_valid && wr_ready) sent++;
            @(posedge clk);
        end
        for (int i = 0; i < 80 && rcvd < sent; i++) begin
            @(negedge clk);
            wr_valid = 1'b0;
            rd_ready = 1'b1;
            if (rd_valid) begin
                chk("bp_drain_data", rd_data, rcvd[7:0]);
                rcvd++;
            end
            @(posedge clk);
        end
        @(negedge clk);
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        chk("bp_rcvd_eq_sent", rcvd, sent);
        chk("bp_end_count", count, 0);

        // mid-operation reset with count = 7 and a read in flight
        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            wr_valid = 1'b1;
            wr_data = 8'h80 + 8'(i);
            @(posedge clk);
        end
        @(negedge clk);
        wr_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("mr_pre_count", count, 8);
        rd_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("mr_count7", count, 7);
        #1;
        rst_n = 1'b0;
        rd_ready = 1'b0;
        wr_valid = 1'b1;
        wr_data = 8'h3C;
        #1;
        chk("mr_rd_valid", rd_valid, 0);
        chk("mr_rd_data", rd_data, 0);
        chk("mr_count", count, 0);
        chk("mr_wr_ready", wr_ready, 1);
        chk("mr_mem_we_a", mem_we_a, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wr_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 10 && !rd_valid; i++) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk("mr_new_valid", rd_valid, 1);
        chk("mr_new_data", rd_data, 8'h3C);
        chk("mr_new_count", count, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bram_fifo_ctrl.md
Name: bram_fifo_ctrl

Overview:
- Controller that turns the synchronous dual-port BRAM into a first-word-fall-through FIFO with valid/ready handshakes on both sides.
- Port A is the write port. Port B is the read port, with 1-cycle registered read latency.
- Sits directly upstream of the BRAM and drives its address, data and write-enable pins.
- A 2-entry output buffer hides the BRAM read latency, so sustained throughput is one word per cycle.

Parameters:
- ADDR_WIDTH, 10: BRAM address width. Storage depth DEPTH = 2**ADDR_WIDTH.
- DATA_WIDTH, 8: word width; must match the BRAM.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_valid  in  1  producer has a word.
- wr_ready  out  1  FIFO accepts; a write occurs when wr_valid && wr_ready.
- wr_data  in  DATA_WIDTH  word to store.
- rd_valid  out  1  rd_data holds the head word.
- rd_ready  in  1  consumer takes; a pop occurs when rd_valid && rd_ready.
- rd_data  out  DATA_WIDTH  head word.
- count  out  ADDR_WIDTH+2  total words held (BRAM + in-flight read + output buffer).
- mem_addr_a  out  ADDR_WIDTH  BRAM write address (wr_ptr).
- mem_din_a  out  DATA_WIDTH  equals wr_data.
- mem_we_a  out  1  equals the write-accept condition.
- mem_addr_b  out  ADDR_WIDTH  BRAM read address (rd_ptr).
- mem_dout_b  in  DATA_WIDTH  BRAM read data, valid the cycle after the read issue.
- mem_we_b  out  1  tied 0.

Behaviour:
- Reset (async assert, sync release):
  - wr_ptr = rd_ptr = 0, mem_count = 0, inflight = 0, out_occ = 0.
  - Outputs: rd_valid = 0, rd_data = 0, wr_ready = 1, count = 0, mem_we_a = 0.
  - Reset mid-operation discards all contents. A pending BRAM read is ignored.
- Write path:
  - wr_ready = (mem_count != DEPTH).
  - On accept: BRAM location wr_ptr is written, wr_ptr increments modulo DEPTH (natural wrap), mem_count increments.
- Read issue: rd_en = (mem_count != 0) && (out_occ + inflight − pop < 2).
  - mem_count counts only words written in earlier cycles. A read therefore never targets the address being written in the same cycle, so no read-during-write hazard exists.
  - On rd_en: rd_ptr increments with wrap, mem_count decrements. inflight next = rd_en.
  - A write and a read-issue in the same cycle leave mem_count unchanged.
- Capture: when inflight = 1, mem_dout_b is pushed into the output buffer in that cycle.
- Output buffer: 2-entry FIFO with states EMPTY, ONE, TWO.
  - rd_valid = (out_occ != 0). rd_data is the head entry.
  - Push and pop in the same cycle keep the occupancy and advance the head.
  - rd_data holds stable while rd_valid && !rd_ready.
- Latency:
  - Empty FIFO: a write accepted at edge N gives rd_valid = 1 after edge N+2.
  - Steady streaming: one word per cycle in each direction.
- count = mem_count + inflight + out_occ, updated at each edge. Maximum value is DEPTH+2.
- Full: writes stall only when the BRAM holds DEPTH words. The output buffer and in-flight read add 2 words of slack.
- Empty: rd_valid = 0 and rd_ready is ignored.
- Ordering: strict FIFO order across pointer wrap.

Optional Feature:
- Macro: BRAM_FIFO_STATS_EN.
- When defined, two extra outputs exist:
  - max_level [ADDR_WIDTH+1:0]: high-watermark of count.
  - ovf_attempts [15:0]: counts cycles with wr_valid && !wr_ready; saturates at 16'hFFFF.
  - Both reset to 0 on rst_n.
- When not defined, neither port nor register exists, and behaviour is otherwise identical.

Decomposition:
- Package bram_fifo_pkg holds:
  - typedef enum out_occ_t {OUT_EMPTY, OUT_ONE, OUT_TWO}.
  - Localparam helper for the count width.
- Sub-module fifo_out_skid holds the 2-entry output buffer: push/data in, valid/ready/data out, occupancy out.
- The top level holds the pointers, mem_count, inflight and read-issue logic.

Test Plan:
- Single word:
  - Stimulus: after reset, write 8'hA5 at cycle 0 with rd_ready = 0.
  - Required: rd_valid rises after edge 2, rd_data = A5, count = 1. Popping it returns count to 0 and rd_valid to 0.
- Streaming:
  - Stimulus: wr_valid = 1 and rd_ready = 1 continuously, data 0..255.
  - Required: in-order output, one word per cycle after 2-cycle fill, count never exceeds 3.
- Fill to full:
  - Stimulus: ADDR_WIDTH = 4, rd_ready = 0, write 0..19.
  - Required: 18 words accepted (16 BRAM + 2 buffer), wr_ready = 0, count = 18. Draining outputs 0..17.
- Wrap:
  - Stimulus: ADDR_WIDTH = 4, alternate bursts of 10 writes and 10 reads for 5 rounds.
  - Required: data matches a scoreboard, pointers wrap cleanly.
- Backpressure:
  - Stimulus: random rd_ready at 30 % with continuous writes.
  - Required: rd_data stable while stalled, no loss or duplication.
- Mid-operation reset:
  - Stimulus: assert rst_n low asynchronously with count = 7 and a read in flight.
  - Required: outputs immediately take reset values. After release, a new write of 8'h3C is the first word read.
